// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS lightweight-bridge PIO blocks: register
// map and edge-capture encodings.
package soc_system_pio_pkg;

  localparam int PIO_DATA_W = 32;

  // Avalon word addresses of the PIO register file.
  typedef enum logic [1:0] {
    PIO_ADDR_DATA = 2'd0,
    PIO_ADDR_RSVD = 2'd1,
    PIO_ADDR_MASK = 2'd2,
    PIO_ADDR_EDGE = 2'd3
  } pio_addr_e;

  // Which transition of a synchronised input sets its capture bit.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_pio_key_in_if.sv
// Avalon-MM slave bus for the key-input PIO. The bridge side is the
// master; the PIO is the slave. There is no waitrequest: reads return one
// cycle after the access.
interface soc_system_pio_key_in_if;
  import soc_system_pio_pkg::*;

  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [PIO_DATA_W-1:0] writedata;
  logic [PIO_DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/soc_system_sync_ff.sv
// Multi-stage flop synchroniser for a bus of independent asynchronous
// inputs. Each bit is synchronised on its own; no cross-bit coherency.
module soc_system_sync_ff #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Stage 0 is the metastability-catching flop; the last stage is the output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the inputs one stage per clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the whole chain is reset (it is flops, not a RAM), so the edge
      // detector downstream always starts from a known all-zero history.
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_key_in.sv
// Key/switch input PIO: synchronises board inputs, exposes the live level,
// latches selected edges into a sticky write-1-to-clear capture register
// and raises a level interrupt for any captured bit enabled in the mask.
module soc_system_pio_key_in
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  soc_system_pio_key_in_if.slave  avs,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  // Edge detection stays off until the synchroniser and prev_q hold real
  // samples, so inputs already asserted at reset never look like edges.
  localparam int                  PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int                  PRIME_W      = $clog2(PRIME_CYCLES + 1);
  localparam logic [PRIME_W-1:0]  PRIME_DONE   = PRIME_W'(PRIME_CYCLES);

  logic [WIDTH-1:0]      sync_q;
  logic [WIDTH-1:0]      prev_q;
  logic [WIDTH-1:0]      capture_q, capture_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [PRIME_W-1:0]    prime_cnt_q, prime_cnt_d;
  logic [PIO_DATA_W-1:0] readdata_q, readdata_d;
  logic                  irq_q, irq_d;

  logic                  armed;
  logic                  rd_en;
  logic                  wr_en;
  logic [WIDTH-1:0]      edge_hit;
  logic [WIDTH-1:0]      clr_bits;

  // Upper write-data bits beyond WIDTH have no register behind them.
  logic                  unused_wdata;
  assign unused_wdata = ^avs.writedata;

  soc_system_sync_ff #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (sync_q)
  );

  assign armed = (prime_cnt_q == PRIME_DONE);
  assign rd_en = avs.chipselect &  avs.write_n;
  assign wr_en = avs.chipselect & ~avs.write_n;

  // Per-bit edge detect on the synchronised level, gated while priming.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    edge_hit = '0;
    if (armed) begin
      if (EDGE_TYPE == EDGE_FALLING)  edge_hit = ~sync_q &  prev_q;
      else if (EDGE_TYPE == EDGE_ANY) edge_hit =  sync_q ^  prev_q;
      else                            edge_hit =  sync_q & ~prev_q;
    end
  end

  // Register-file next state: mask, capture (edge beats clear), irq, priming.
  always_comb begin
    mask_d   = mask_q;
    clr_bits = '0;
    if (wr_en && (avs.address == PIO_ADDR_MASK)) mask_d   = avs.writedata[WIDTH-1:0];
    if (wr_en && (avs.address == PIO_ADDR_EDGE)) clr_bits = avs.writedata[WIDTH-1:0];

    capture_d   = (capture_q & ~clr_bits) | edge_hit;
    irq_d       = |(capture_d & mask_d);
    prime_cnt_d = armed ? prime_cnt_q : prime_cnt_q + PRIME_W'(1);
  end

  // Read mux: captured into readdata on a read, held otherwise.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      case (avs.address)
        PIO_ADDR_DATA: readdata_d[WIDTH-1:0] = sync_q;
        PIO_ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
        PIO_ADDR_EDGE: readdata_d[WIDTH-1:0] = capture_q;
        default:       readdata_d = '0;
      endcase
    end
  end

  // State registers; reset clears everything and restarts priming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q      <= '0;
      capture_q   <= '0;
      mask_q      <= RESET_MASK;
      prime_cnt_q <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // prev_q must see the old sync_q, not the one updated this edge.
      prev_q      <= sync_q;
      capture_q   <= capture_d;
      mask_q      <= mask_d;
      prime_cnt_q <= prime_cnt_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
